// File: rtl/demux_ex_if.sv
// Handshake bundle for the 1-to-2 demux: one sender port, two consumer ports and the debug counters.
// master = sender/consumer side, slave = the demux itself.
interface demux_ex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] entrada;
    logic              sel;
    logic              entrada_valid;
    logic              entrada_ready;
    logic [DATA_W-1:0] salida_0;
    logic              salida_0_valid;
    logic              salida_0_ready;
    logic [DATA_W-1:0] salida_1;
    logic              salida_1_valid;
    logic              salida_1_ready;
    logic [CNT_W-1:0]  cuenta_0;
    logic [CNT_W-1:0]  cuenta_1;

    modport master (
        output entrada, sel, entrada_valid, salida_0_ready, salida_1_ready,
        input  entrada_ready, salida_0, salida_0_valid, salida_1, salida_1_valid,
        input  cuenta_0, cuenta_1
    );

    modport slave (
        input  entrada, sel, entrada_valid, salida_0_ready, salida_1_ready,
        output entrada_ready, salida_0, salida_0_valid, salida_1, salida_1_valid,
        output cuenta_0, cuenta_1
    );
endinterface

// File: rtl/demux_ex.sv
// Registered 1-to-2 demux with one holding register per channel; accepted word visible 1 cycle later.
// Backpressure is per channel: only inputs steered to a stalled channel see entrada_ready=0.
module demux_ex #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    demux_ex_if.slave   bus
);
    logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic              vld0_q, vld0_d, vld1_q, vld1_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              free0, free1, acc0, acc1, dlv0, dlv1;

    // A channel is free when empty or draining this cycle; ready never looks at entrada_valid.
    assign free0 = !vld0_q || bus.salida_0_ready;
    assign free1 = !vld1_q || bus.salida_1_ready;
    assign bus.entrada_ready = bus.sel ? free1 : free0;

    assign acc0 = bus.entrada_valid && !bus.sel && free0;
    assign acc1 = bus.entrada_valid &&  bus.sel && free1;
    assign dlv0 = vld0_q && bus.salida_0_ready;
    assign dlv1 = vld1_q && bus.salida_1_ready;

    always_comb begin
        dat0_d = dat0_q;
        vld0_d = vld0_q;
        cnt0_d = cnt0_q;
        dat1_d = dat1_q;
        vld1_d = vld1_q;
        cnt1_d = cnt1_q;

        if (acc0) begin
            dat0_d = bus.entrada;
            vld0_d = 1'b1;
        end else if (dlv0) begin
            vld0_d = 1'b0;
        end
        if (dlv0) cnt0_d = cnt0_q + 1'b1;

        if (acc1) begin
            dat1_d = bus.entrada;
            vld1_d = 1'b1;
        end else if (dlv1) begin
            vld1_d = 1'b0;
        end
        if (dlv1) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat0_q <= '0;
            vld0_q <= 1'b0;
            cnt0_q <= '0;
            dat1_q <= '0;
            vld1_q <= 1'b0;
            cnt1_q <= '0;
        end else begin
            dat0_q <= dat0_d;
            vld0_q <= vld0_d;
            cnt0_q <= cnt0_d;
            dat1_q <= dat1_d;
            vld1_q <= vld1_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.salida_0       = dat0_q;
    assign bus.salida_0_valid = vld0_q;
    assign bus.cuenta_0       = cnt0_q;
    assign bus.salida_1       = dat1_q;
    assign bus.salida_1_valid = vld1_q;
    assign bus.cuenta_1       = cnt1_q;
endmodule

// File: tb/tb_demux_ex.sv
// Scoreboard bench for demux_ex: each channel is modelled as a one-slot buffer holding an ordered
// queue of expected words; a negedge monitor pops and compares on every delivery.
module tb_demux_ex;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int MODV   = 1 << CNT_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    demux_ex_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    demux_ex #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int cnt0 = 0;
    int cnt1 = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Sender must hold a refused transfer unchanged.
    property p_hold;
        @(posedge clk) disable iff (reset)
            (bus.entrada_valid && !bus.entrada_ready) |=>
            (bus.entrada_valid && $stable(bus.entrada) && $stable(bus.sel));
    endproperty
    a_hold: assume property (p_hold);

    // Monitor: counters first, then output presence/data, then retire delivered words.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cuenta_0", {28'b0, bus.cuenta_0}, cnt0 % MODV);
            chk("cuenta_1", {28'b0, bus.cuenta_1}, cnt1 % MODV);
            chk("salida_0_valid", {31'b0, bus.salida_0_valid}, {31'b0, q0.size() != 0});
            chk("salida_1_valid", {31'b0, bus.salida_1_valid}, {31'b0, q1.size() != 0});
            if (q0.size() != 0) begin
                chk("salida_0", bus.salida_0, q0[0]);
                if (bus.salida_0_ready) begin
                    void'(q0.pop_front());
                    cnt0++;
                end
            end
            if (q1.size() != 0) begin
                chk("salida_1", bus.salida_1, q1[0]);
                if (bus.salida_1_ready) begin
                    void'(q1.pop_front());
                    cnt1++;
                end
            end
        end
    end

    // One cycle of stimulus; expected ready is "slot empty after this cycle's delivery".
    task automatic step(input logic v, input logic s, input logic [31:0] d,
                        input logic r0, input logic r1, output logic acc);
        logic er;
        @(posedge clk);
        #1;
        bus.entrada_valid  = v;
        bus.sel            = s;
        bus.entrada        = d;
        bus.salida_0_ready = r0;
        bus.salida_1_ready = r1;
        #5;
        er = s ? (q1.size() == 0) : (q0.size() == 0);
        chk("entrada_ready", {31'b0, bus.entrada_ready}, {31'b0, er});
        acc = v && er;
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_salida_0"}, bus.salida_0, 32'h0);
        chk({tag, "_salida_1"}, bus.salida_1, 32'h0);
        chk({tag, "_valid_0"}, {31'b0, bus.salida_0_valid}, 32'h0);
        chk({tag, "_valid_1"}, {31'b0, bus.salida_1_valid}, 32'h0);
        chk({tag, "_cuenta_0"}, {28'b0, bus.cuenta_0}, 32'h0);
        chk({tag, "_cuenta_1"}, {28'b0, bus.cuenta_1}, 32'h0);
    endtask

    initial begin
        logic acc;
        logic pv, ps, r0, r1;
        logic [31:0] pd;
        int c_before;

        bus.entrada_valid  = 1'b0;
        bus.sel            = 1'b0;
        bus.entrada        = '0;
        bus.salida_0_ready = 1'b0;
        bus.salida_1_ready = 1'b0;
        #3;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic steer.
        step(1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, acc);
        chk("steer_acc0", {31'b0, acc}, 32'h1);
        step(1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, acc);
        chk("steer_acc1", {31'b0, acc}, 32'h1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("steer_cnt0", {28'b0, bus.cuenta_0}, 32'h1);
        chk("steer_cnt1", {28'b0, bus.cuenta_1}, 32'h1);

        // Backpressure on channel 1: second word refused until the consumer drains.
        step(1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, acc);
        chk("bp_first_acc", {31'b0, acc}, 32'h1);
        step(1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b0, acc);
        chk("bp_second_refused", {31'b0, acc}, 32'h0);
        step(1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b0, acc);
        chk("bp_still_refused", {31'b0, acc}, 32'h0);
        chk("bp_held_data", bus.salida_1, 32'hA5A5A5A5);
        step(1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, acc);
        chk("bp_swap_acc", {31'b0, acc}, 32'h1);

        // Channel 1 stalled full; channel 0 must still accept.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 32'h0000CAFE, 1'b1, 1'b0, acc);
        chk("indep_acc", {31'b0, acc}, 32'h1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        chk("indep_ch1_held", bus.salida_1, 32'h5A5A5A5A);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

        // Streaming: 100 back-to-back words into channel 0.
        c_before = cnt0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 32'h1000_0000 + i, 1'b1, 1'b0, acc);
            chk("stream_acc", {31'b0, acc}, 32'h1);
        end
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("stream_cnt", {28'b0, bus.cuenta_0}, (c_before + 100) % MODV);

        // Counter wrap: 17 deliveries on channel 1.
        c_before = cnt1;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b1, $urandom, 1'b0, 1'b1, acc);
            chk("wrap_acc", {31'b0, acc}, 32'h1);
        end
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("wrap_cnt", {28'b0, bus.cuenta_1}, (c_before + 17) % MODV);

        // Random traffic, holding refused transfers unchanged.
        pv = 1'b0; ps = 1'b0; pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 9) < 7);
                ps = 1'($urandom_range(0, 1));
                pd = $urandom;
            end
            r0 = ($urandom_range(0, 9) < 6);
            r1 = ($urandom_range(0, 9) < 6);
            step(pv, ps, pd, r0, r1, acc);
            if (acc) pv = 1'b0;
        end
        for (int i = 0; i < 4 && pv; i++) begin
            step(pv, ps, pd, 1'b1, 1'b1, acc);
            if (acc) pv = 1'b0;
        end
        if (pv) chk("random_drain", 32'h0, 32'h1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);

        // Reset mid-transfer with a stalled word on channel 0.
        step(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, acc);
        chk("rst_load_acc", {31'b0, acc}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        chk("rst_pre_valid", {31'b0, bus.salida_0_valid}, 32'h1);
        chk("rst_pre_data", bus.salida_0, 32'hDEADBEEF);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk_zero("async_rst");
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_zero("post_rst");
        mon_en = 1'b1;
        step(1'b1, 1'b0, 32'h0BADF00D, 1'b1, 1'b1, acc);
        chk("post_rst_acc", {31'b0, acc}, 32'h1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, acc);
        chk("post_rst_cnt", {28'b0, bus.cuenta_0}, 32'h1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
